// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator.
//   NOTE_W / DUR_W : field widths of a queued note
//   note_entry_t   : one pending note {note, duration}
//   REST_NOTE      : note code that means "rest" (never loads a player)
package voice_alloc_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } note_entry_t;

  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;
endpackage

// File: rtl/note_fifo.sv
// Pending-note FIFO, first-word-fall-through from a register array.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, push_data : write request and entry
//   pop             : remove head (ignored when empty)
//   head            : current head entry (valid when !empty)
//   empty, full     : occupancy flags
//   count           : number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
module note_fifo
  import voice_alloc_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = note_entry_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  entry_t                  push_data,
  input  logic                    pop,
  output entry_t                  head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: queues notes from the song reader and dispatches each
// to the lowest-index idle note player, one dispatch per cycle.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   new_note, note, duration : incoming note request
//   note_done                : per-player completion pulses
//   voice_load               : one-hot registered load pulse
//   voice_note/voice_duration: payload for the loaded player (held otherwise)
//   voice_busy               : per-player busy flags
//   queue_empty/queue_full   : FIFO occupancy flags
//   overflow                 : one-cycle pulse when an incoming note is dropped
// Optional feature macro VOICE_STEAL_EN: when the FIFO is full, all voices
// are busy and another note arrives, the head is loaded onto the oldest
// voice instead of dropping the new note.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES  = 3,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_note,
  input  logic [NOTE_W-1:0]     note,
  input  logic [DUR_W-1:0]      duration,
  input  logic [NUM_VOICES-1:0] note_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  queue_empty,
  output logic                  queue_full,
  output logic                  overflow
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  note_entry_t           head;
  note_entry_t           push_entry;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic                  at_capacity;
  logic [NUM_VOICES-1:0] idle;
  logic [NUM_VOICES-1:0] idle_pick;
  logic                  any_idle;
  logic                  head_is_rest;
  logic                  steal;
  logic                  pop;
  logic [NUM_VOICES-1:0] load_vec;
  logic                  overflow_next;

  assign push_entry = '{note: note, duration: duration};

  note_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (note_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (new_note),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign queue_empty  = fifo_empty;
  assign queue_full   = fifo_full;
  assign at_capacity  = (fifo_count == FULL_COUNT);
  assign idle         = ~voice_busy;
  // Isolate the lowest set bit of the idle mask.
  assign idle_pick    = idle & (~idle + 1'b1);
  assign any_idle     = |idle;
  assign head_is_rest = (head.note == REST_NOTE);

  // Rests leave the queue as soon as they reach the head, even with no idle voice.
  assign pop           = (~fifo_empty & (head_is_rest | any_idle)) | steal;
  assign overflow_next = new_note & at_capacity & ~pop;

`ifdef VOICE_STEAL_EN
  localparam int AW = $clog2(NUM_VOICES);

  // Age rank 0 is the oldest voice, NUM_VOICES-1 the most recently loaded.
  logic [AW-1:0]         age [NUM_VOICES];
  logic [AW-1:0]         loaded_age;
  logic [NUM_VOICES-1:0] oldest;

  assign steal = new_note & at_capacity & ~any_idle & ~head_is_rest;

  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_VOICES; i++) oldest[i] = (age[i] == '0);
  end

  always_comb begin
    load_vec = '0;
    if (!fifo_empty && !head_is_rest) begin
      if (any_idle)   load_vec = idle_pick;
      else if (steal) load_vec = oldest;
    end
  end

  always_comb begin
    loaded_age = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (load_vec[i]) loaded_age = age[i];
  end

  // Loaded voice becomes youngest; voices younger than it move one step older.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= AW'(i);
    end else if (|load_vec) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_vec[i])              age[i] <= AW'(NUM_VOICES - 1);
        else if (age[i] > loaded_age) age[i] <= age[i] - 1'b1;
      end
    end
  end
`else
  assign steal = 1'b0;

  always_comb begin
    load_vec = '0;
    if (!fifo_empty && !head_is_rest && any_idle) load_vec = idle_pick;
  end
`endif

  // OR-ing the load back in keeps a stolen voice busy even if its note_done
  // lands in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voice_load     <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
      voice_busy     <= '0;
      overflow       <= 1'b0;
    end else begin
      voice_load <= load_vec;
      if (|load_vec) begin
        voice_note     <= head.note;
        voice_duration <= head.duration;
      end
      voice_busy <= (voice_busy & ~note_done) | load_vec;
      overflow   <= overflow_next;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  localparam int NV = 3;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_note = 1'b0;
  logic [5:0]    note = '0;
  logic [5:0]    duration = '0;
  logic [NV-1:0] note_done = '0;
  logic [NV-1:0] voice_load;
  logic [5:0]    voice_note;
  logic [5:0]    voice_duration;
  logic [NV-1:0] voice_busy;
  logic          queue_empty;
  logic          queue_full;
  logic          overflow;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .QUEUE_DEPTH(QD)) dut (
    .clk            (clk),
    .reset          (reset),
    .new_note       (new_note),
    .note           (note),
    .duration       (duration),
    .note_done      (note_done),
    .voice_load     (voice_load),
    .voice_note     (voice_note),
    .voice_duration (voice_duration),
    .voice_busy     (voice_busy),
    .queue_empty    (queue_empty),
    .queue_full     (queue_full),
    .overflow       (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic nn, input logic [5:0] n, input logic [5:0] d,
                       input logic [NV-1:0] dn);
    new_note  = nn;
    note      = n;
    duration  = d;
    note_done = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, '0);
    #2 reset = 1'b0;
    tick();
    tick();
    #3 reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic          nn;
    logic [5:0]    n;
    logic [5:0]    d;
    logic [NV-1:0] done;
    logic [NV-1:0] load;
    logic [5:0]    vn;
    logic [5:0]    vd;
    logic [NV-1:0] busy;
    logic          empty;
    logic          full;
    logic          ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic nn, input logic [5:0] n, input logic [5:0] d,
                              input logic [NV-1:0] done, input logic [NV-1:0] load,
                              input logic [5:0] vn, input logic [5:0] vd,
                              input logic [NV-1:0] busy, input logic empty,
                              input logic full, input logic ovf);
    vec_t v;
    v.nn = nn; v.n = n; v.d = d; v.done = done; v.load = load; v.vn = vn; v.vd = vd;
    v.busy = busy; v.empty = empty; v.full = full; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Behavioural model state
  typedef struct {
    logic [5:0] n;
    logic [5:0] d;
  } ent_t;
  ent_t          mq[$];
  logic [NV-1:0] mbusy;
  logic [5:0]    mnote;
  logic [5:0]    mdur;
`ifdef VOICE_STEAL_EN
  int            order[$];
`endif

  initial begin
    // ---- reset state ----
    #2;
    chk("reset_load", voice_load, 0);
    chk("reset_busy", voice_busy, 0);
    chk("reset_empty", queue_empty, 1);
    chk("reset_full", queue_full, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_note", voice_note, 0);
    do_reset();

    // ---- table-driven vectors ----
    //   nn  n   d  done   load    vn  vd  busy   e  f  o
    add(1, 12, 4, 3'b000, 3'b000,  0, 0, 3'b000, 0, 0, 0);
    add(1, 13, 5, 3'b000, 3'b001, 12, 4, 3'b001, 0, 0, 0);
    add(1, 14, 6, 3'b000, 3'b010, 13, 5, 3'b011, 0, 0, 0);
    add(1, 15, 7, 3'b000, 3'b100, 14, 6, 3'b111, 0, 0, 0);
    add(0,  0, 0, 3'b000, 3'b000,  0, 0, 3'b111, 0, 0, 0);
    add(0,  0, 0, 3'b010, 3'b000,  0, 0, 3'b101, 0, 0, 0);
    add(0,  0, 0, 3'b000, 3'b010, 15, 7, 3'b111, 1, 0, 0);
    add(1, 20, 1, 3'b000, 3'b000,  0, 0, 3'b111, 0, 0, 0);
    add(1, 21, 2, 3'b000, 3'b000,  0, 0, 3'b111, 0, 0, 0);
    add(1, 22, 3, 3'b000, 3'b000,  0, 0, 3'b111, 0, 0, 0);
    add(1, 23, 4, 3'b000, 3'b000,  0, 0, 3'b111, 0, 1, 0);
`ifdef VOICE_STEAL_EN
    add(1, 24, 5, 3'b000, 3'b001, 20, 1, 3'b111, 0, 1, 0);
    add(0,  0, 0, 3'b000, 3'b000,  0, 0, 3'b111, 0, 1, 0);
    add(0,  0, 0, 3'b100, 3'b000,  0, 0, 3'b011, 0, 1, 0);
    add(0,  0, 0, 3'b000, 3'b100, 21, 2, 3'b111, 0, 0, 0);
    add(0,  0, 0, 3'b001, 3'b000,  0, 0, 3'b110, 0, 0, 0);
    add(0,  0, 0, 3'b000, 3'b001, 22, 3, 3'b111, 0, 0, 0);
`else
    add(1, 24, 5, 3'b000, 3'b000,  0, 0, 3'b111, 0, 1, 1);
    add(0,  0, 0, 3'b000, 3'b000,  0, 0, 3'b111, 0, 1, 0);
    add(0,  0, 0, 3'b100, 3'b000,  0, 0, 3'b011, 0, 1, 0);
    add(0,  0, 0, 3'b000, 3'b100, 20, 1, 3'b111, 0, 0, 0);
    add(0,  0, 0, 3'b001, 3'b000,  0, 0, 3'b110, 0, 0, 0);
    add(0,  0, 0, 3'b000, 3'b001, 21, 2, 3'b111, 0, 0, 0);
`endif
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].nn, vecs[k].n, vecs[k].d, vecs[k].done);
      tick();
      $display("vec %0d: load=%b busy=%b empty=%b full=%b ovf=%b note=%0d",
               k, voice_load, voice_busy, queue_empty, queue_full, overflow, voice_note);
      chk("vec_load", voice_load, vecs[k].load);
      chk("vec_busy", voice_busy, vecs[k].busy);
      chk("vec_empty", queue_empty, vecs[k].empty);
      chk("vec_full", queue_full, vecs[k].full);
      chk("vec_ovf", overflow, vecs[k].ovf);
      if (vecs[k].load != '0) begin
        chk("vec_note", voice_note, vecs[k].vn);
        chk("vec_dur", voice_duration, vecs[k].vd);
      end
    end

    // ---- rest ahead of a real note with all voices busy ----
    do_reset();
    drive(1, 1, 1, '0); tick();
    drive(1, 2, 1, '0); tick();
    drive(1, 3, 1, '0); tick();
    drive(1, 0, 5, '0); tick();
    chk("rest_busy_all", voice_busy, 3'b111);
    drive(1, 20, 9, '0); tick();
    chk("rest_no_load", voice_load, 0);
    chk("rest_queued20", queue_empty, 0);
    drive(0, 0, 0, '0); tick();
    chk("rest_still_no_load", voice_load, 0);
    drive(0, 0, 0, 3'b010); tick();
    chk("rest_busy_cleared", voice_busy, 3'b101);
    chk("rest_load_wait", voice_load, 0);
    drive(0, 0, 0, '0); tick();
    $display("rest seq: load=%b note=%0d dur=%0d", voice_load, voice_note, voice_duration);
    chk("rest_load20", voice_load, 3'b010);
    chk("rest_note20", voice_note, 20);
    chk("rest_dur20", voice_duration, 9);
    chk("rest_empty", queue_empty, 1);

    // ---- asynchronous reset with entries queued ----
    drive(1, 30, 1, '0); tick();
    drive(1, 31, 2, '0); tick();
    drive(1, 32, 3, '0); tick();
    drive(0, 0, 0, '0);
    chk("pre_reset_queued", queue_empty, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_load", voice_load, 0);
    chk("async_rst_busy", voice_busy, 0);
    chk("async_rst_empty", queue_empty, 1);
    chk("async_rst_note", voice_note, 0);
    chk("async_rst_dur", voice_duration, 0);
    #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_no_load", voice_load, 0);
      chk("post_rst_empty", queue_empty, 1);
    end

    // ---- randomized run against the behavioural model ----
    do_reset();
    mq.delete();
    mbusy = '0;
    mnote = '0;
    mdur  = '0;
`ifdef VOICE_STEAL_EN
    order.delete();
    for (int v = 0; v < NV; v++) order.push_back(v);
`endif
    for (int c = 0; c < 1500; c++) begin
      logic          nn;
      logic [5:0]    n;
      logic [5:0]    d;
      logic [NV-1:0] dn;
      logic [NV-1:0] exp_load;
      logic          exp_ovf;
      int            tgt;
      nn = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      d  = 6'($urandom_range(0, 63));
      for (int v = 0; v < NV; v++) dn[v] = ($urandom_range(0, 3) == 0);
      drive(nn, n, d, dn);

      exp_load = '0;
      exp_ovf  = 1'b0;
      tgt      = -1;
      if (mq.size() > 0) begin
        if (mq[0].n == 0) begin
          void'(mq.pop_front());
        end else begin
          for (int v = NV - 1; v >= 0; v--) if (!mbusy[v]) tgt = v;
`ifdef VOICE_STEAL_EN
          if (tgt < 0 && nn && mq.size() == QD) tgt = order[0];
`endif
          if (tgt >= 0) begin
            exp_load[tgt] = 1'b1;
            mnote = mq[0].n;
            mdur  = mq[0].d;
            void'(mq.pop_front());
`ifdef VOICE_STEAL_EN
            for (int k = 0; k < order.size(); k++)
              if (order[k] == tgt) begin
                order.delete(k);
                break;
              end
            order.push_back(tgt);
`endif
          end
        end
      end
      if (nn) begin
        if (mq.size() == QD) exp_ovf = 1'b1;
        else begin
          ent_t e;
          e.n = n;
          e.d = d;
          mq.push_back(e);
        end
      end
      mbusy = (mbusy & ~dn) | exp_load;

      tick();
      chk("rnd_load", voice_load, exp_load);
      chk("rnd_busy", voice_busy, mbusy);
      chk("rnd_empty", queue_empty, (mq.size() == 0));
      chk("rnd_full", queue_full, (mq.size() == QD));
      chk("rnd_ovf", overflow, exp_ovf);
      chk("rnd_note", voice_note, mnote);
      chk("rnd_dur", voice_duration, mdur);
    end
    $display("random run: %0d cycles done", 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
